vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
Vending-machine control FSM directly downstream of the four-key debouncer. Consumes the debouncer's one-cycle, active-high key pulses: 0.5-yuan coin, 1-yuan coin, select and cancel. Tracks credit in half-yuan units, drives a timed dispense output and pays change back as spaced coin pulses. Its outputs feed the display and actuator stages.

Parameters:
PRICE, 5, item price in half-yuan units (2.5 yuan).
MAX_CREDIT, 15, credit ceiling in half-yuan units; must fit in 5 bits, and PRICE <= MAX_CREDIT.
DISP_CYCLES, 50_000_000, dispense hold time in clk cycles (1 s at 50 MHz); must be >= 1.
GAP_CYCLES, 25_000_000, spacing between change pulses in clk cycles; must be >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
key_pulse  input  4  debounced one-cycle pulses: [0] coin 0.5, [1] coin 1, [2] select, [3] cancel
credit  output  5  current credit in half-yuan units
dispense  output  1  high while the item is being released
change_1  output  1  one-cycle pulse, return one 1-yuan coin
change_05  output  1  one-cycle pulse, return one 0.5-yuan coin
coin_reject  output  1  one-cycle pulse, a coin was refused (over ceiling)
short_funds  output  1  one-cycle pulse, select pressed with credit < PRICE
busy  output  1  high in DISPENSE or CHANGE

Behaviour:
- Reset: state IDLE, credit 0, timer 0, all outputs 0. Reset mid-dispense or mid-change aborts immediately; credit is lost.
- All outputs are registered. Every response appears on the clk edge after the key pulse is sampled (latency 1).
- States: IDLE (credit == 0), CREDIT (credit > 0), DISPENSE, CHANGE.
- Key priority when several bits are set in one cycle: cancel > select > coin1 > coin0.5. Only the highest-priority bit acts; the others are dropped silently.
- IDLE/CREDIT, coin: new = credit + 1 (coin 0.5) or + 2 (coin 1).
  - If new <= MAX_CREDIT: credit <= new; move to CREDIT.
  - Otherwise: credit unchanged; coin_reject pulses for 1 cycle.
- IDLE/CREDIT, select:
  - If credit >= PRICE: credit <= credit - PRICE; enter DISPENSE; dispense goes high next cycle.
  - Otherwise: short_funds pulses for 1 cycle; state unchanged.
- IDLE/CREDIT, cancel:
  - If credit > 0: enter CHANGE.
  - If credit == 0: no effect.
- DISPENSE:
  - dispense is high for exactly DISP_CYCLES cycles.
  - All keys are ignored, including cancel.
  - At the end: go to CHANGE if credit > 0, else IDLE. dispense drops in the same cycle as the state leaves.
- CHANGE:
  - All keys are ignored.
  - The first change pulse is issued on the first cycle in CHANGE; each later pulse follows GAP_CYCLES cycles after the previous one.
  - Each pulse: if credit >= 2, change_1 and credit -= 2; else change_05 and credit -= 1.
  - The cycle after the pulse that brings credit to 0, the state returns to IDLE.
  - Only one change pulse is ever asserted per cycle.
- busy = (state == DISPENSE or CHANGE), registered.
- Arithmetic:
  - credit is 5-bit unsigned.
  - The coin add is computed 6 bits wide, so MAX_CREDIT + 2 cannot wrap.
  - Subtraction is only performed when its guard holds, so underflow cannot occur.
- Timer: one shared down-counter, width $clog2(max(DISP_CYCLES, GAP_CYCLES)) + 1.
  - Loaded on entry to DISPENSE, and after each change pulse.
  - Zero is the expiry condition.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, CREDIT, DISPENSE, CHANGE);
  - key index constants (KEY_C05=0, KEY_C1=1, KEY_SEL=2, KEY_CAN=3);
  - coin value constants (V_05=1, V_1=2).
- One natural sub-module, vend_timer: loadable down-counter with load value, load strobe and a zero flag. It is instantiated once in vend_ctrl.

Test Plan (bench overrides: PRICE=5, MAX_CREDIT=15, DISP_CYCLES=4, GAP_CYCLES=3):
1. Reset then idle: all outputs 0, credit 0; drive rst_n low mid-DISPENSE -> dispense, busy and credit all 0 asynchronously.
2. coin1 x3, then select -> credit reads 2, 4, 6, then 1; dispense high exactly 4 cycles; then one change_05 pulse; credit 0; IDLE (busy low).
3. coin0.5 x2, then select -> short_funds pulses once, credit stays 2, state CREDIT; then cancel -> change_1 one pulse, credit 0, IDLE.
4. coin1 x7 (credit 14), then coin1 -> coin_reject pulse, credit 14; coin0.5 -> credit 15; cancel -> change_1 x7 spaced 3 cycles apart, then change_05 x1, then IDLE.
5. key_pulse=4'b1111 with credit 6 -> only cancel acts: CHANGE entered, credit not incremented, no dispense.
6. Keys pressed during DISPENSE and during CHANGE (coin, select, cancel) -> ignored; credit and pulse counts identical to the undisturbed run.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending-machine controller.
//   state_t   - controller states (IDLE, CREDIT, DISPENSE, CHANGE)
//   KEY_*     - bit positions inside the debounced key_pulse vector
//   V_05/V_1  - coin values in half-yuan units, 6 bits wide so that the
//               credit + coin sum never wraps
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int KEY_C05 = 0;
  localparam int KEY_C1  = 1;
  localparam int KEY_SEL = 2;
  localparam int KEY_CAN = 3;

  localparam logic [5:0] V_05 = 6'd1;
  localparam logic [5:0] V_1  = 6'd2;

endpackage

// File: rtl/vend_if.sv
// vend_if: key input and status/actuator outputs of the vending controller.
//   key_pulse   - debounced one-cycle key pulses (coin 0.5, coin 1, select, cancel)
//   credit      - current credit in half-yuan units
//   dispense    - item release, held high for the dispense time
//   change_1    - one-cycle pulse, return a 1-yuan coin
//   change_05   - one-cycle pulse, return a 0.5-yuan coin
//   coin_reject - one-cycle pulse, coin refused (ceiling exceeded)
//   short_funds - one-cycle pulse, select with insufficient credit
//   busy        - high while dispensing or paying change
// Modports: master = key source / display side, slave = controller.
interface vend_if;
  logic [3:0] key_pulse;
  logic [4:0] credit;
  logic       dispense;
  logic       change_1;
  logic       change_05;
  logic       coin_reject;
  logic       short_funds;
  logic       busy;

  modport master (
    output key_pulse,
    input  credit, dispense, change_1, change_05, coin_reject, short_funds, busy
  );

  modport slave (
    input  key_pulse,
    output credit, dispense, change_1, change_05, coin_reject, short_funds, busy
  );
endinterface

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter shared by the dispense hold and the
// change-pulse spacing.
//   clk, rst_n - clock and asynchronous active-low reset
//   load       - load strobe, takes priority over counting
//   load_val   - value loaded on load
//   zero       - counter has reached zero (it then holds at zero)
module vend_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine control FSM fed by the four-key debouncer.
// Tracks credit in half-yuan units, releases an item for DISP_CYCLES
// cycles and pays change back as pulses spaced GAP_CYCLES apart.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (aborts dispense/change, credit lost)
//   bus   - vend_if slave: key_pulse in; credit, dispense, change_1,
//           change_05, coin_reject, short_funds, busy out (all registered)
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int MAX_CREDIT  = 15,
  parameter int DISP_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input logic   clk,
  input logic   rst_n,
  vend_if.slave bus
);

  localparam int TMR_SPAN = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
  localparam int TMR_W    = $clog2(TMR_SPAN) + 1;

  // The timer expires on zero, so a hold of N cycles loads N-1.
  localparam logic [TMR_W-1:0] DISP_LOAD = TMR_W'(DISP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       PRICE_V   = 5'(PRICE);
  localparam logic [5:0]       MAX_V     = 6'(MAX_CREDIT);

  state_t     state;
  logic [4:0] credit;
  logic       dispense;
  logic       change_1;
  logic       change_05;
  logic       coin_reject;
  logic       short_funds;
  logic       busy;

  logic             can_key;
  logic             sel_key;
  logic             c1_key;
  logic             c05_key;
  logic [5:0]       coin_sum;
  logic             in_entry;
  logic             do_sell;
  logic             do_refund;
  logic             disp_done;
  logic             chg_next;
  logic             do_pulse;
  logic             pulse_big;
  logic [4:0]       credit_after_pulse;
  logic             timer_load;
  logic [TMR_W-1:0] timer_val;
  logic             timer_zero;

  // Key decode with priority cancel > select > coin1 > coin0.5, plus the
  // events that need the timer reloaded.
  always_comb begin
    can_key   = bus.key_pulse[KEY_CAN];
    sel_key   = bus.key_pulse[KEY_SEL] & ~can_key;
    c1_key    = bus.key_pulse[KEY_C1]  & ~can_key & ~sel_key;
    c05_key   = bus.key_pulse[KEY_C05] & ~can_key & ~sel_key & ~c1_key;
    coin_sum  = {1'b0, credit} + (c1_key ? V_1 : V_05);

    in_entry  = (state == IDLE) || (state == CREDIT);
    do_sell   = in_entry && sel_key && (credit >= PRICE_V);
    do_refund = in_entry && can_key && (credit != 5'd0);
    disp_done = (state == DISPENSE) && timer_zero;
    chg_next  = (state == CHANGE) && (credit != 5'd0) && timer_zero;
    // A change pulse is issued on the very edge that enters CHANGE and
    // then every GAP_CYCLES while credit remains.
    do_pulse  = do_refund || (disp_done && (credit != 5'd0)) || chg_next;

    pulse_big          = (credit >= 5'd2);
    credit_after_pulse = pulse_big ? (credit - 5'd2) : (credit - 5'd1);

    timer_load = do_sell || do_pulse;
    timer_val  = do_sell ? DISP_LOAD : GAP_LOAD;
  end

  vend_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= 5'd0;
      dispense    <= 1'b0;
      change_1    <= 1'b0;
      change_05   <= 1'b0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
      busy        <= 1'b0;
    end else begin
      change_1    <= 1'b0;
      change_05   <= 1'b0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;

      if (do_pulse) begin
        change_1  <= pulse_big;
        change_05 <= ~pulse_big;
        credit    <= credit_after_pulse;
      end

      case (state)
        IDLE, CREDIT: begin
          if (can_key) begin
            if (credit != 5'd0) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end
          end else if (sel_key) begin
            if (credit >= PRICE_V) begin
              credit   <= credit - PRICE_V;
              state    <= DISPENSE;
              dispense <= 1'b1;
              busy     <= 1'b1;
            end else begin
              short_funds <= 1'b1;
            end
          end else if (c1_key || c05_key) begin
            if (coin_sum <= MAX_V) begin
              credit <= coin_sum[4:0];
              state  <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        DISPENSE: begin
          if (timer_zero) begin
            dispense <= 1'b0;
            if (credit != 5'd0) begin
              state <= CHANGE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        CHANGE: begin
          // One idle cycle after the pulse that emptied the credit.
          if (credit == 5'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit      = credit;
  assign bus.dispense    = dispense;
  assign bus.change_1    = change_1;
  assign bus.change_05   = change_05;
  assign bus.coin_reject = coin_reject;
  assign bus.short_funds = short_funds;
  assign bus.busy        = busy;

endmodule
